pulse_cmd_regs: RTL and testbench
=================================

PULSE_CMD_REGS -- requirements
Module: pulse_cmd_regs

Interface
REQ-001 Parameter NUM_REGS, default 8: number of control registers; legal range 1..128.
REQ-002 Parameter DATA_BYTES, default 4: payload bytes per frame and register width in bytes; legal range 1..8.
REQ-003 Parameter TIMEOUT_CYC, default 1200000: idle clk cycles between frame bytes before the partial frame is discarded.
REQ-004 Parameter RESET_VALS, default all zero: NUM_REGS*DATA_BYTES*8-bit vector; register i resets to slice i.
REQ-005 clk  input  1  single system clock; all logic is rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 rx_valid  input  1  one-cycle pulse; rx_byte holds a received UART byte.
REQ-008 rx_byte  input  8  received byte.
REQ-009 tx_busy  input  1  UART transmitter busy.
REQ-010 tx_start  output  1  one-cycle request to transmit tx_byte.
REQ-011 tx_byte  output  8  byte to transmit; stable from tx_start until the next tx_start.
REQ-012 regs_out  output  NUM_REGS*DATA_BYTES*8  flat register file; register i occupies slice i.
REQ-013 wr_strobe  output  1  one-cycle pulse when a register is written.
REQ-014 wr_index  output  7  index of the last written register.
REQ-015 busy  output  1  high in every state except RECV.
REQ-016 frame_err  output  1  one-cycle pulse on timeout discard or bad index.

Function
REQ-017 Frame format: DATA_BYTES payload bytes, least significant first, then one control byte. Control bit 7: 1 = read, 0 = write. Control bits 6:0: register index.
REQ-018 State machine RECV -> EXEC -> SEND -> RECV.
- RECV collects bytes.
- EXEC lasts exactly one cycle.
- SEND drains the response queue.
REQ-019 In RECV, each rx_valid stores rx_byte at the current byte count and increments the count. The byte arriving at count DATA_BYTES is the control byte and moves the machine to EXEC on the next edge.
REQ-020 rx_valid arriving outside RECV SHALL be ignored.
REQ-021 Checksum SHALL be the 8-bit modulo-256 sum of the payload bytes; carries are discarded.
REQ-022 Write with index < NUM_REGS:
- In EXEC, the register is loaded with the payload.
- wr_strobe pulses the same cycle; wr_index is updated the same cycle.
- regs_out reflects the new value on the following cycle.
- Response is 1 byte: the checksum.
REQ-023 Read with index < NUM_REGS: no register changes. Response is DATA_BYTES bytes of the register value (LSB first), then the checksum of those returned bytes.
REQ-024 Index >= NUM_REGS: no register changes; frame_err pulses in EXEC; response is the single byte 0xEE.
REQ-025 SEND handshake:
- tx_start is asserted only when tx_busy = 0.
- After each tx_start, tx_busy is ignored for one cycle, then the block waits for tx_busy = 0 before the next byte.
- After the last byte's wait completes, the machine returns to RECV.
REQ-026 Timeout: in RECV with byte count > 0, a counter counts cycles since the last rx_valid. When it reaches TIMEOUT_CYC, the byte count clears, frame_err pulses, and no response is sent. The counter is held at 0 while the byte count is 0.
REQ-027 An rx_valid in the same cycle the timeout fires SHALL be accepted as byte 0 of a new frame.
REQ-028 Byte counter and timeout counter widths SHALL be sized by $clog2 of their maxima; neither SHALL wrap.

Reset
REQ-029 rst = 1 forces the following on the next edge, from any state including mid-frame and mid-SEND:
- state RECV
- byte count 0
- regs_out = RESET_VALS
- tx_start, wr_strobe, frame_err = 0
- wr_index = 0, tx_byte = 0
- busy = 0
- timeout counter 0
REQ-030 A response in progress is abandoned; no further tx_start is issued after reset.

Structure
REQ-031 Package pulse_cmd_pkg holds the state enum, the read-flag bit position, and the error byte constant 0xEE.
REQ-032 One sub-module: pulse_cmd_txq, a response byte queue of depth DATA_BYTES+1, loaded in EXEC and popped by the SEND handshake.

Verification
REQ-033 Write: bytes 0x10,0x27,0x00,0x00,0x02 -> register 2 = 0x00002710; wr_strobe one cycle with wr_index = 2; tx_byte 0x37.
REQ-034 Read after REQ-033 (payload 0,0,0,0; control 0x82) -> tx_byte sequence 0x10,0x27,0x00,0x00,0x37; register 2 unchanged.
REQ-035 Checksum wrap: payload 0xFF,0xFF,0x01,0x00 to register 0 -> response 0xFF.
REQ-036 Control 0x09 with NUM_REGS = 8 -> frame_err pulse, response 0xEE, no wr_strobe.
REQ-037 Two payload bytes then a TIMEOUT_CYC-cycle gap -> frame_err pulse; the next full 5-byte frame is decoded correctly.
REQ-038 rst asserted after the 3rd byte and again mid-SEND -> all outputs at reset values; no stray tx_start; the following frame is decoded correctly.

Source files
------------

// File: rtl/pulse_cmd_pkg.sv
// Shared types and constants for the pulse_cmd_regs UART register block.
package pulse_cmd_pkg;

    typedef enum logic [1:0] {
        StRecv,
        StExec,
        StSend
    } state_e;

    // Sub-phase of SEND: wait for an idle transmitter, or skip the cycle after a start.
    typedef enum logic [0:0] {
        PhWait,
        PhHold
    } send_phase_e;

    localparam int unsigned ReadBit = 7;
    localparam logic [7:0]  ErrByte = 8'hEE;

endpackage

// File: rtl/pulse_cmd_txq.sv
// Response byte queue: parallel load of up to DEPTH bytes, popped one byte at a time.
module pulse_cmd_txq
    import pulse_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned LEN_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DEPTH*8-1:0] load_data,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               pop,
    output logic [7:0]         head,
    output logic               empty
);

    logic [7:0]       mem_q [DEPTH];
    logic [LEN_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (load) begin
            cnt_q <= load_len;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= load_data[i*8 +: 8];
            end
        end else if (pop && (cnt_q != '0)) begin
            cnt_q <= cnt_q - LEN_W'(1);
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_q[i] <= mem_q[i+1];
            end
            mem_q[DEPTH-1] <= '0;
        end
    end

    assign head  = mem_q[0];
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/pulse_cmd_regs.sv
// UART-framed register file: collects payload+control frames, writes or reads a register,
// and returns a checksum / data response through a byte queue.
module pulse_cmd_regs
    import pulse_cmd_pkg::*;
#(
    parameter int unsigned                       NUM_REGS    = 8,
    parameter int unsigned                       DATA_BYTES  = 4,
    parameter int unsigned                       TIMEOUT_CYC = 1200000,
    parameter logic [NUM_REGS*DATA_BYTES*8-1:0]  RESET_VALS  = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx_valid,
    input  logic [7:0]                       rx_byte,
    input  logic                             tx_busy,
    output logic                             tx_start,
    output logic [7:0]                       tx_byte,
    output logic [NUM_REGS*DATA_BYTES*8-1:0] regs_out,
    output logic                             wr_strobe,
    output logic [6:0]                       wr_index,
    output logic                             busy,
    output logic                             frame_err
);

    localparam int unsigned RegW   = DATA_BYTES * 8;
    localparam int unsigned CntW   = $clog2(DATA_BYTES + 1);
    localparam int unsigned ToW    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned QDepth = DATA_BYTES + 1;
    localparam int unsigned QLenW  = $clog2(QDepth + 1);

    localparam logic [CntW-1:0] CtrlPos = CntW'(DATA_BYTES);
    localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT_CYC);

    state_e                           state_q, state_d;
    send_phase_e                      phase_q, phase_d;
    logic [CntW-1:0]                  cnt_q, cnt_d;
    logic [ToW-1:0]                   to_q, to_d;
    logic [RegW-1:0]                  pay_q;
    logic [7:0]                       ctrl_q;
    logic [NUM_REGS*DATA_BYTES*8-1:0] regs_q;
    logic [6:0]                       wr_index_q;
    logic [7:0]                       tx_byte_q;

    logic              byte_we;
    logic [CntW-1:0]   byte_pos;
    logic              timeout_fire;
    logic [6:0]        idx;
    logic              idx_ok;
    logic              is_read;
    logic [31:0]       sel;
    logic [RegW-1:0]   reg_val;
    logic [7:0]        pay_sum;
    logic [7:0]        reg_sum;
    logic              q_load;
    logic              q_pop;
    logic [QDepth*8-1:0] q_data;
    logic [QLenW-1:0]  q_len;
    logic [7:0]        q_head;
    logic              q_empty;

    assign idx     = ctrl_q[6:0];
    assign is_read = ctrl_q[ReadBit];
    assign idx_ok  = (32'(idx) < NUM_REGS);
    assign sel     = idx_ok ? 32'(idx) : 32'd0;
    assign reg_val = regs_q[sel*RegW +: RegW];

    // Modulo-256 sums; the 8-bit accumulators drop carries naturally.
    always_comb begin
        pay_sum = '0;
        reg_sum = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            pay_sum = pay_sum + pay_q[i*8 +: 8];
            reg_sum = reg_sum + reg_val[i*8 +: 8];
        end
    end

    always_comb begin
        q_data = '0;
        q_len  = QLenW'(1);
        if (!idx_ok) begin
            q_data[7:0] = ErrByte;
        end else if (is_read) begin
            q_data[RegW-1:0]   = reg_val;
            q_data[RegW +: 8]  = reg_sum;
            q_len              = QLenW'(QDepth);
        end else begin
            q_data[7:0] = pay_sum;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        to_d         = to_q;
        byte_we      = 1'b0;
        byte_pos     = cnt_q;
        timeout_fire = 1'b0;
        q_load       = 1'b0;
        q_pop        = 1'b0;
        tx_start     = 1'b0;
        wr_strobe    = 1'b0;
        frame_err    = 1'b0;

        unique case (state_q)
            StRecv: begin
                if (cnt_q == '0) begin
                    to_d = '0;
                end else if (to_q == ToMax) begin
                    timeout_fire = 1'b1;
                    cnt_d        = '0;
                    to_d         = '0;
                    byte_pos     = '0;
                end else begin
                    to_d = to_q + ToW'(1);
                end
                // A byte landing on the timeout cycle starts a fresh frame at position 0.
                if (rx_valid) begin
                    byte_we = 1'b1;
                    to_d    = '0;
                    if (byte_pos == CtrlPos) begin
                        cnt_d   = '0;
                        state_d = StExec;
                    end else begin
                        cnt_d = byte_pos + CntW'(1);
                    end
                end
                frame_err = timeout_fire;
            end
            StExec: begin
                q_load    = 1'b1;
                wr_strobe = idx_ok && !is_read;
                frame_err = !idx_ok;
                phase_d   = PhWait;
                state_d   = StSend;
            end
            StSend: begin
                if (phase_q == PhHold) begin
                    phase_d = PhWait;
                end else if (!tx_busy) begin
                    if (!q_empty) begin
                        tx_start = 1'b1;
                        q_pop    = 1'b1;
                        phase_d  = PhHold;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            default: state_d = StRecv;
        endcase

        if (rst) begin
            tx_start  = 1'b0;
            wr_strobe = 1'b0;
            frame_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRecv;
            phase_q    <= PhWait;
            cnt_q      <= '0;
            to_q       <= '0;
            pay_q      <= '0;
            ctrl_q     <= '0;
            regs_q     <= RESET_VALS;
            wr_index_q <= '0;
            tx_byte_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            if (byte_we) begin
                if (byte_pos == CtrlPos) begin
                    ctrl_q <= rx_byte;
                end else begin
                    for (int i = 0; i < DATA_BYTES; i++) begin
                        if (byte_pos == CntW'(i)) begin
                            pay_q[i*8 +: 8] <= rx_byte;
                        end
                    end
                end
            end
            if (wr_strobe) begin
                regs_q[sel*RegW +: RegW] <= pay_q;
                wr_index_q               <= idx;
            end
            if (tx_start) begin
                tx_byte_q <= q_head;
            end
        end
    end

    pulse_cmd_txq #(
        .DEPTH (QDepth),
        .LEN_W (QLenW)
    ) u_txq (
        .clk       (clk),
        .rst       (rst),
        .load      (q_load),
        .load_data (q_data),
        .load_len  (q_len),
        .pop       (q_pop),
        .head      (q_head),
        .empty     (q_empty)
    );

    assign busy     = (state_q != StRecv);
    assign regs_out = regs_q;
    assign wr_index = wr_strobe ? idx : wr_index_q;
    // The byte being started is shown in its own start cycle, then held until the next start.
    assign tx_byte  = tx_start ? q_head : tx_byte_q;

endmodule

// File: tb/tb_pulse_cmd_regs.sv
// Randomized frame-level bench for pulse_cmd_regs against a register-array reference model.
module tb_pulse_cmd_regs;

    localparam int unsigned NR = 8;
    localparam int unsigned DB = 4;
    localparam int unsigned TO = 40;
    localparam logic [255:0] RV = {32'hA5A5_0007, 32'hA5A5_0006, 32'hA5A5_0005,
                                   32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002,
                                   32'hA5A5_0001, 32'hA5A5_0000};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         tx_busy = 1'b0;
    logic         tx_start;
    logic [7:0]   tx_byte;
    logic [255:0] regs_out;
    logic         wr_strobe;
    logic [6:0]   wr_index;
    logic         busy;
    logic         frame_err;

    pulse_cmd_regs #(
        .NUM_REGS    (NR),
        .DATA_BYTES  (DB),
        .TIMEOUT_CYC (TO),
        .RESET_VALS  (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mregs [NR];
    logic [7:0]  got_tx [$];
    logic [7:0]  exp_tx [$];
    int          got_wr [$];
    int          ferr_cnt = 0;
    int          exp_wr_idx = -1;
    int          exp_ferr = 0;
    int          last_wr = 0;
    logic [31:0] exp_wr_val = '0;
    int          busy_load = 0;
    int          busy_cnt = 0;
    logic [7:0]  last_tx = 8'h00;
    logic        pend_wr = 1'b0;
    int          pend_idx = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            last_tx = 8'h00;
            pend_wr = 1'b0;
        end else begin
            if (pend_wr) begin
                check_eq("wr_visible", regs_out[pend_idx*32 +: 32], exp_wr_val);
                pend_wr = 1'b0;
            end
            if (tx_start) begin
                check_eq("start_idle", tx_busy, 1'b0);
                got_tx.push_back(tx_byte);
                last_tx   = tx_byte;
                busy_load = 1;
            end else begin
                check_eq("tx_hold", tx_byte, last_tx);
            end
            if (wr_strobe) begin
                got_wr.push_back(int'(wr_index));
                pend_wr  = 1'b1;
                pend_idx = int'(wr_index);
            end
            if (frame_err) ferr_cnt++;
        end
    end

    // UART transmitter model: busy for a few cycles after each start, plus random busy noise.
    always @(posedge clk) begin
        #1;
        if (busy_load != 0) begin
            busy_cnt  = $urandom_range(1, 4);
            busy_load = 0;
        end
        if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
        end else begin
            tx_busy = ($urandom_range(0, 4) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [255:0] model_flat();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = mregs[i];
        return v;
    endfunction

    task automatic model_reset();
        logic [255:0] rv_v;
        rv_v = RV;
        for (int i = 0; i < NR; i++) mregs[i] = rv_v[i*32 +: 32];
        last_wr = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] pay, input logic [7:0] ctrl, input int gap);
        for (int i = 0; i < DB; i++) begin
            send_byte(pay[i*8 +: 8]);
            tick(gap >= 0 ? gap : int'($urandom_range(0, 3)));
        end
        send_byte(ctrl);
    endtask

    task automatic expect_frame(input logic [31:0] pay, input logic [7:0] ctrl);
        int idx;
        int s;
        int b;
        idx = int'(ctrl[6:0]);
        exp_tx.delete();
        exp_wr_idx = -1;
        exp_ferr   = 0;
        s          = 0;
        if (idx >= int'(NR)) begin
            exp_tx.push_back(8'hEE);
            exp_ferr = 1;
        end else if (ctrl[7]) begin
            for (int i = 0; i < DB; i++) begin
                b = int'((mregs[idx] >> (8 * i)) & 32'hFF);
                s += b;
                exp_tx.push_back(8'(b));
            end
            exp_tx.push_back(8'(s % 256));
        end else begin
            for (int i = 0; i < DB; i++) s += int'((pay >> (8 * i)) & 32'hFF);
            exp_tx.push_back(8'(s % 256));
            mregs[idx] = pay;
            exp_wr_idx = idx;
            exp_wr_val = pay;
            last_wr    = idx;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            tick(1);
            n++;
        end
        check_eq("idle_bound", busy, 1'b0);
    endtask

    task automatic check_results();
        int n;
        check_eq("tx_count", got_tx.size(), exp_tx.size());
        n = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
        for (int i = 0; i < n; i++) check_eq("tx_byte", got_tx[i], exp_tx[i]);
        check_eq("wr_count", got_wr.size(), (exp_wr_idx >= 0) ? 1 : 0);
        if (got_wr.size() > 0 && exp_wr_idx >= 0) check_eq("wr_index", got_wr[0], exp_wr_idx);
        check_eq("frame_err_cnt", ferr_cnt, exp_ferr);
        check_eq("regs_out", regs_out, model_flat());
        check_eq("wr_index_hold", wr_index, last_wr);
    endtask

    task automatic clear_obs();
        got_tx.delete();
        got_wr.delete();
        ferr_cnt = 0;
    endtask

    // lead=1 prefixes a junk byte and exactly TO idle cycles, so byte 0 lands on the timeout.
    task automatic do_frame(input logic [31:0] pay, input logic [7:0] ctrl, input int gap,
                            input bit lead);
        clear_obs();
        if (lead) begin
            send_byte(8'h5A);
            tick(TO);
        end
        expect_frame(pay, ctrl);
        if (lead) exp_ferr += 1;
        send_frame(pay, ctrl, gap);
        wait_idle();
        check_results();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state();
        check_eq("rst_regs", regs_out, RV);
        check_eq("rst_wr_index", wr_index, 7'd0);
        check_eq("rst_tx_byte", tx_byte, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_tx_start", tx_start, 1'b0);
        check_eq("rst_wr_strobe", wr_strobe, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
    endtask

    initial begin
        int n;
        int op;
        logic [7:0] ctrl;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_reset();
        check_reset_state();

        // Worked examples: write, read-back, checksum wrap, bad index.
        do_frame(32'h0000_2710, 8'h02, 1, 1'b0);
        do_frame(32'h0000_0000, 8'h82, 0, 1'b0);
        do_frame(32'h0001_FFFF, 8'h00, 2, 1'b0);
        do_frame(32'h1234_5678, 8'h09, 0, 1'b0);
        do_frame(32'hDEAD_BEEF, 8'h07, -1, 1'b0);
        do_frame(32'h0000_0000, 8'h87, -1, 1'b0);
        do_frame(32'h0000_0000, 8'h88, -1, 1'b0);
        do_frame(32'hCAFE_F00D, 8'h7F, -1, 1'b0);

        // Timeout with a long gap discards the partial frame silently.
        clear_obs();
        send_byte(8'h11);
        tick(1);
        send_byte(8'h22);
        tick(TO + 3);
        check_eq("to_ferr", ferr_cnt, 1);
        check_eq("to_no_tx", got_tx.size(), 0);
        check_eq("to_busy", busy, 1'b0);
        do_frame(32'h0BAD_F00D, 8'h03, -1, 1'b0);

        // Gaps one short of the timeout keep the frame alive; exact timeout restarts it.
        do_frame(32'h5555_AAAA, 8'h04, int'(TO) - 1, 1'b0);
        do_frame(32'h0102_0304, 8'h05, -1, 1'b1);
        do_frame(32'h0, 8'h85, -1, 1'b0);

        // Reset mid-frame.
        clear_obs();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        do_reset();
        check_reset_state();
        do_frame(32'h7777_0001, 8'h06, -1, 1'b0);

        // Reset mid-response: no further starts afterwards.
        clear_obs();
        send_frame(32'h0, 8'h86, -1);
        n = 0;
        while (got_tx.size() < 2 && n < 1000) begin
            tick(1);
            n++;
        end
        check_eq("midsend_reached", got_tx.size() >= 2, 1'b1);
        got_tx.delete();
        do_reset();
        check_reset_state();
        tick(20);
        check_eq("stray_start", got_tx.size(), 0);
        do_frame(32'h0, 8'h86, -1, 1'b0);
        do_frame(32'h9999_8888, 8'h01, -1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 9));
            if (op < 4) ctrl = 8'($urandom_range(0, NR - 1));
            else if (op < 8) ctrl = 8'h80 | 8'($urandom_range(0, NR - 1));
            else ctrl = {1'($urandom_range(0, 1)), 7'($urandom_range(NR, 127))};
            do_frame($urandom, ctrl, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
